// File: rtl/uart_rx_if.sv
// Result bus of the UART receiver: serial input side plus the received-byte strobe.
// Handshake: valid is a one-clk strobe with no ready/backpressure; data, parity_err and
// frame_err are registered and stay stable from one valid strobe to the next.
interface uart_rx_if;
  logic       rx;
  logic       sample_tick;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    input  sample_tick,
    output data,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    output sample_tick,
    input  data,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8E1 UART receiver with oversampled centre sampling, framing/parity checks and
// break detection; all timing is counted in sample_tick pulses.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_if.master       bus,
  output logic [2:0]      dbg_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bad_q, par_bad_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          tick;

  assign tick = bus.sample_tick;

  // rx is asynchronous to clk; idle-high reset value avoids a false start after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tick && !rx_s_q) state_d = START;
      end
      START: begin
        if (tick) begin
          if (cnt_q == HALF_M1) begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            // A start bit that is high again at its centre was only a glitch.
            state_d   = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == FULL_M1) begin
            cnt_d     = '0;
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (cnt_q == FULL_M1) begin
            cnt_d     = '0;
            par_bad_d = rx_s_q ^ (^shift_q);
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt_q == FULL_M1) begin
            cnt_d        = '0;
            data_d       = shift_q;
            parity_err_d = par_bad_q;
            frame_err_d  = ~rx_s_q;
            valid_d      = 1'b1;
            // A low stop bit may be the start of a break; wait for the line to recover.
            state_d      = rx_s_q ? IDLE : BREAK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (tick && rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);
  assign dbg_state      = state_q;

endmodule
